lifo_stack_param: RTL and testbench

Parametrised synchronous LIFO stack (push-down buffer register) with independent push and pop strobes, registered pop data, and an occupancy count. It adds almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a defined simultaneous push+pop (replace-top) mode. It sits between a producer and consumer in the buffer-register family, where last-in-first-out ordering is required at any width and depth.

---
 rtl/lifo_stack_param.sv | 115 +++++++++++
 tb/tb_lifo_stack_param.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/lifo_stack_param.sv
// Parametrised synchronous LIFO stack with registered pop data, occupancy count,
// almost-full/almost-empty thresholds, sticky error flags and a replace-top push+pop mode.
module lifo_stack_param #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             EN,
    input  logic             Push,
    input  logic             Pop,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut,
    output logic             dataValid,
    output logic [WIDTH-1:0] Top,
    output logic [CW-1:0]    Count,
    output logic             EMPTY,
    output logic             FULL,
    output logic             ALMOST_EMPTY,
    output logic             ALMOST_FULL,
    output logic             OVERFLOW,
    output logic             UNDERFLOW
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_m1;
    logic [AW-1:0]    top_idx;
    logic             empty_i;
    logic             full_i;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;

    assign count_m1 = count_q - CW'(1);
    assign top_idx  = count_m1[AW-1:0];
    assign empty_i  = (count_q == '0);
    assign full_i   = (count_q == DEPTH_C);

    assign Count        = count_q;
    assign EMPTY        = empty_i;
    assign FULL         = full_i;
    assign ALMOST_FULL  = (count_q >= AF_C);
    assign ALMOST_EMPTY = (count_q <= AE_C);
    assign Top          = empty_i ? '0 : mem[top_idx];

    // A plain push writes the free slot; push+pop on a non-empty stack overwrites the top.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = top_idx;
        if (!Rst && EN && Push) begin
            if (!Pop && !full_i) begin
                mem_we    = 1'b1;
                mem_waddr = count_q[AW-1:0];
            end else if (Pop && !empty_i) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= dataIn;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            count_q   <= '0;
            dataOut   <= '0;
            dataValid <= 1'b0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else if (!EN) begin
            dataValid <= 1'b0;
        end else begin
            case ({Push, Pop})
                2'b10: begin
                    dataValid <= 1'b0;
                    if (full_i) begin
                        OVERFLOW <= 1'b1;
                    end else begin
                        count_q <= count_q + CW'(1);
                    end
                end
                2'b01: begin
                    if (empty_i) begin
                        dataValid <= 1'b0;
                        UNDERFLOW <= 1'b1;
                    end else begin
                        dataOut   <= mem[top_idx];
                        dataValid <= 1'b1;
                        count_q   <= count_m1;
                    end
                end
                2'b11: begin
                    // Empty stack bypasses the pushed word straight to the output.
                    dataValid <= 1'b1;
                    dataOut   <= empty_i ? dataIn : mem[top_idx];
                end
                default: begin
                    dataValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lifo_stack_param.sv
// Directed plus short random testbench for lifo_stack_param, checked against a queue-based
// stack model with a scoreboard of expected popped words.
module tb_lifo_stack_param;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             Clk = 1'b0;
    logic             Rst = 1'b0;
    logic             EN = 1'b0;
    logic             Push = 1'b0;
    logic             Pop = 1'b0;
    logic [WIDTH-1:0] dataIn = '0;
    logic [WIDTH-1:0] dataOut;
    logic             dataValid;
    logic [WIDTH-1:0] Top;
    logic [CW-1:0]    Count;
    logic             EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL, OVERFLOW, UNDERFLOW;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] model_stk [$];
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] model_dout = '0;
    logic             model_ovf = 1'b0;
    logic             model_unf = 1'b0;

    lifo_stack_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Rst(Rst), .EN(EN), .Push(Push), .Pop(Pop), .dataIn(dataIn),
        .dataOut(dataOut), .dataValid(dataValid), .Top(Top), .Count(Count),
        .EMPTY(EMPTY), .FULL(FULL), .ALMOST_EMPTY(ALMOST_EMPTY), .ALMOST_FULL(ALMOST_FULL),
        .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock of stimulus: update the model, apply the edge, then compare everything.
    task automatic applyStimulus(input logic rst, input logic en, input logic push,
                                 input logic pop, input logic [WIDTH-1:0] din);
        logic exp_valid;
        int   n;
        logic [WIDTH-1:0] exp_top;
        exp_valid = 1'b0;
        if (rst) begin
            model_stk.delete();
            model_dout = '0;
            model_ovf  = 1'b0;
            model_unf  = 1'b0;
        end else if (en) begin
            if (push && !pop) begin
                if (model_stk.size() == DEPTH) model_ovf = 1'b1;
                else model_stk.push_back(din);
            end else if (!push && pop) begin
                if (model_stk.size() == 0) model_unf = 1'b1;
                else begin
                    model_dout = model_stk.pop_back();
                    exp_valid  = 1'b1;
                end
            end else if (push && pop) begin
                exp_valid = 1'b1;
                if (model_stk.size() == 0) model_dout = din;
                else begin
                    model_dout = model_stk.pop_back();
                    model_stk.push_back(din);
                end
            end
        end
        if (exp_valid) exp_q.push_back(model_dout);

        Rst = rst; EN = en; Push = push; Pop = pop; dataIn = din;
        @(posedge Clk);
        #1;
        n = model_stk.size();
        exp_top = (n > 0) ? model_stk[n-1] : '0;
        checkOutput("dataValid", 32'(dataValid), 32'(exp_valid));
        if (dataValid && exp_q.size() > 0) checkOutput("pop_data", 32'(dataOut), 32'(exp_q.pop_front()));
        checkOutput("dataOut", 32'(dataOut), 32'(model_dout));
        checkOutput("Count", 32'(Count), 32'(n));
        checkOutput("Top", 32'(Top), 32'(exp_top));
        checkOutput("EMPTY", 32'(EMPTY), 32'(n == 0));
        checkOutput("FULL", 32'(FULL), 32'(n == DEPTH));
        checkOutput("ALMOST_FULL", 32'(ALMOST_FULL), 32'(n >= DEPTH - 1));
        checkOutput("ALMOST_EMPTY", 32'(ALMOST_EMPTY), 32'(n <= 1));
        checkOutput("OVERFLOW", 32'(OVERFLOW), 32'(model_ovf));
        checkOutput("UNDERFLOW", 32'(UNDERFLOW), 32'(model_unf));
    endtask

    initial begin
        // Reset with EN low
        applyStimulus(1, 0, 0, 0, 4'h0);
        checkOutput("reset_count", 32'(Count), 32'd0);
        checkOutput("reset_empty", 32'(EMPTY), 32'd1);

        // Fill 1..4, then overflow attempt with 5
        applyStimulus(0, 1, 1, 0, 4'h1);
        applyStimulus(0, 1, 1, 0, 4'h2);
        applyStimulus(0, 1, 1, 0, 4'h3);
        checkOutput("af_at_3", 32'(ALMOST_FULL), 32'd1);
        applyStimulus(0, 1, 1, 0, 4'h4);
        checkOutput("full_top", 32'(Top), 32'h4);
        applyStimulus(0, 1, 1, 0, 4'h5);
        checkOutput("ovf_count", 32'(Count), 32'd4);

        // Drain: expect 4,3,2,1 then underflow
        applyStimulus(0, 1, 0, 1, 4'h0);
        checkOutput("drain_first", 32'(dataOut), 32'h4);
        applyStimulus(0, 1, 0, 1, 4'h0);
        applyStimulus(0, 1, 0, 1, 4'h0);
        applyStimulus(0, 1, 0, 1, 4'h0);
        checkOutput("drain_last", 32'(dataOut), 32'h1);
        applyStimulus(0, 1, 0, 1, 4'h0);
        applyStimulus(0, 1, 0, 0, 4'h0);
        checkOutput("flags_sticky", 32'({OVERFLOW, UNDERFLOW}), 32'b11);

        // Replace-top and empty bypass
        applyStimulus(1, 1, 0, 0, 4'h0);
        applyStimulus(0, 1, 1, 0, 4'h1);
        applyStimulus(0, 1, 1, 0, 4'h2);
        applyStimulus(0, 1, 1, 1, 4'h9);
        checkOutput("replace_out", 32'(dataOut), 32'h2);
        checkOutput("replace_top", 32'(Top), 32'h9);
        applyStimulus(0, 1, 0, 1, 4'h0);
        applyStimulus(0, 1, 0, 1, 4'h0);
        applyStimulus(0, 1, 1, 1, 4'h7);
        checkOutput("bypass_out", 32'(dataOut), 32'h7);

        // Full stack replace-top: no error flags
        applyStimulus(1, 0, 0, 0, 4'h0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 1, 0, 4'(i + 10));
        applyStimulus(0, 1, 1, 1, 4'h6);

        // Enable gating with Count=2
        applyStimulus(1, 0, 0, 0, 4'h0);
        applyStimulus(0, 1, 1, 0, 4'h3);
        applyStimulus(0, 1, 1, 0, 4'h8);
        applyStimulus(0, 0, 1, 0, 4'hA);
        applyStimulus(0, 0, 0, 1, 4'h0);
        applyStimulus(0, 0, 1, 1, 4'hB);
        checkOutput("gated_top", 32'(Top), 32'h8);

        // Reset mid-burst with Push asserted
        applyStimulus(1, 1, 0, 0, 4'h0);
        applyStimulus(0, 1, 1, 0, 4'h1);
        applyStimulus(0, 1, 1, 0, 4'h2);
        applyStimulus(0, 1, 1, 0, 4'h3);
        applyStimulus(1, 1, 1, 0, 4'hE);
        applyStimulus(0, 1, 0, 1, 4'h0);
        checkOutput("post_reset_unf", 32'(UNDERFLOW), 32'd1);

        // Short random burst
        applyStimulus(1, 0, 0, 0, 4'h0);
        for (int i = 0; i < 60; i++)
            applyStimulus(0, ($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
                          4'($urandom));

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
